decimal_entry_game: RTL and testbench
=====================================

Name: decimal_entry_game

Overview:
- Reverse-direction mode of the binary converter game: target value shown in binary on the 8 LEDs; player enters the decimal equivalent as three BCD digits with buttons.
- Sits beside the existing game controller. Consumes the shared random source and slow-tick divider; drives the letter/number mux through a 28-bit segment word (via the existing number-to-7seg converter).
- Owns score, digit entry and result display sequencing.

Parameters:
- DEBOUNCE_TICKS, 4, consecutive high ticks before a button press is accepted.
- SHOW_TICKS, 10, ticks the GOOD/FAIL result stays on screen before returning to LOAD.
- TIMEOUT_TICKS, 200, entry timeout in ticks (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  single-cycle enable from slow divider; all timing/debounce advances only on tick
- rand_in  in  8  random value from the shared generator
- up_button  in  1  raw button: increment the selected digit
- next_button  in  1  raw button: move cursor to the next digit
- enter_button  in  1  raw button: submit the entry
- led  out  8  target value in binary
- entry_bcd  out  12  {hundreds, tens, ones} BCD digits being entered
- cursor  out  2  selected digit: 0 = hundreds, 1 = tens, 2 = ones
- score  out  8  consecutive-correct count
- result_good  out  1  high while in SHOW_GOOD
- result_fail  out  1  high while in SHOW_FAIL
- state_out  out  3  current FSM state, for display selection

Behaviour:
- Reset values: led=0, entry_bcd=0, cursor=0, score=0, result_good=0, result_fail=0, state=LOAD; all counters 0.
- Debounce: one instance per button. Raw input is sampled on tick. After the input has been high for DEBOUNCE_TICKS consecutive ticks, a one-clk press pulse is emitted. No further pulse is emitted until the input has been low for at least one tick.
- Only pulses are acted on; holding a button gives a single action.
- FSM, advancing on clk:
  - LOAD (1 cycle): target<=rand_in; led<=rand_in; entry_bcd<=0; cursor<=0; clear counters -> ENTRY.
  - ENTRY, up pulse: increments the selected digit. Hundreds wraps 2->0; tens and ones wrap 9->0.
  - ENTRY, next pulse: cursor 0->1->2->0.
  - ENTRY, enter pulse -> CHECK.
  - ENTRY, simultaneous pulses in the same cycle: enter has priority over up; up has priority over next. Only one action is taken per cycle.
  - CHECK (1 cycle): value = 100*h + 10*t + o, computed at 10 bits.
    - value == target: score saturating +1 (255 stays 255) -> SHOW_GOOD.
    - Otherwise: score <= 0 -> SHOW_FAIL.
  - SHOW_GOOD / SHOW_FAIL: the matching result flag is high. A counter increments on tick; at SHOW_TICKS the counter is cleared and the FSM goes to LOAD.
  - Button pulses in CHECK, SHOW_GOOD, SHOW_FAIL and LOAD are ignored.
- Latency: enter pulse to result flag = 2 clk.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous).
- State encoding: LOAD=0, ENTRY=1, CHECK=2, SHOW_GOOD=3, SHOW_FAIL=4; values 5–7 recover to LOAD.

Optional Feature:
- ENTRY_TIMEOUT_EN defined:
  - An entry counter runs on tick while in ENTRY and clears on any accepted pulse.
  - When the counter reaches TIMEOUT_TICKS: score<=0 -> SHOW_FAIL.
- ENTRY_TIMEOUT_EN undefined: no timeout counter is built; ENTRY waits indefinitely.

Decomposition:
- game_pkg (shared package):
  - FSM state encodings.
  - 28-bit display string constants GOOD, FAIL, SCORE, YOU, SAID, RESET.
  - BCD digit limits (hundreds max 2, others max 9).
- One sub-module: button_debounce (clk, reset, tick, raw in, press pulse out), instantiated three times.

Test Plan:
- Basic correct entry: reset, rand_in=0x2A. Enter digits 0,4,2 via up/next, then enter. Expect SHOW_GOOD, score=1. After SHOW_TICKS ticks, state=LOAD then ENTRY, led=new rand_in.
- Wrong and over-range entry:
  - score=5, target=0xFF, entry 2,5,4 -> SHOW_FAIL, score=0.
  - entry 2,9,9 (value 299) -> SHOW_FAIL.
- Wrap and bounce:
  - up pressed 3 times on hundreds -> digit returns to 0.
  - next pressed 3 times -> cursor 0.
  - A 2-tick glitch on up -> no change.
- Simultaneous pulses and saturation:
  - up and enter debounced in the same cycle -> CHECK taken, digit unchanged.
  - score=255 plus a correct entry -> score stays 255.
- Reset and ignored presses:
  - Reset asserted in SHOW_GOOD between clk edges -> all outputs 0 immediately, state LOAD.
  - Presses during SHOW_FAIL have no effect.
- With ENTRY_TIMEOUT_EN, TIMEOUT_TICKS=20, no presses: SHOW_FAIL after 20 ticks, score=0. Without the macro: remains in ENTRY after 1000 ticks.

Source files
------------

// File: rtl/decimal_entry_game_pkg.sv
// -----------------------------------------------------------------------------
// decimal_entry_game_pkg
// Shared definitions for the decimal-entry game mode:
//   - FSM state encoding (LOAD=0 .. SHOW_FAIL=4)
//   - BCD digit limits for the three-digit entry
//   - 28-bit display words (four 7-segment characters, bit order {g,f,e,d,c,b,a})
//   - helpers for digit increment and BCD-to-binary conversion
// -----------------------------------------------------------------------------
package decimal_entry_game_pkg;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_ENTRY     = 3'd1,
        ST_CHECK     = 3'd2,
        ST_SHOW_GOOD = 3'd3,
        ST_SHOW_FAIL = 3'd4
    } state_e;

    localparam logic [3:0] HUNDREDS_MAX = 4'd2;
    localparam logic [3:0] DIGIT_MAX    = 4'd9;

    // Single characters, active-high segments {g,f,e,d,c,b,a}
    localparam logic [6:0] CH_BLANK = 7'b0000000;
    localparam logic [6:0] CH_A     = 7'b1110111;
    localparam logic [6:0] CH_C     = 7'b0111001;
    localparam logic [6:0] CH_D     = 7'b1011110;
    localparam logic [6:0] CH_E     = 7'b1111001;
    localparam logic [6:0] CH_F     = 7'b1110001;
    localparam logic [6:0] CH_G     = 7'b0111101;
    localparam logic [6:0] CH_I     = 7'b0000110;
    localparam logic [6:0] CH_L     = 7'b0111000;
    localparam logic [6:0] CH_O     = 7'b0111111;
    localparam logic [6:0] CH_R     = 7'b1010000;
    localparam logic [6:0] CH_S     = 7'b1101101;
    localparam logic [6:0] CH_T     = 7'b1111000;
    localparam logic [6:0] CH_U     = 7'b0111110;
    localparam logic [6:0] CH_Y     = 7'b1101110;

    // Four-character display words, leftmost character in the top bits
    localparam logic [27:0] DISP_GOOD  = {CH_G, CH_O, CH_O, CH_D};
    localparam logic [27:0] DISP_FAIL  = {CH_F, CH_A, CH_I, CH_L};
    localparam logic [27:0] DISP_SCORE = {CH_S, CH_C, CH_O, CH_R};
    localparam logic [27:0] DISP_YOU   = {CH_BLANK, CH_Y, CH_O, CH_U};
    localparam logic [27:0] DISP_SAID  = {CH_S, CH_A, CH_I, CH_D};
    localparam logic [27:0] DISP_RESET = {CH_R, CH_E, CH_S, CH_T};

    // Wrapping increment; anything at or above the limit wraps to 0 so a
    // corrupted digit can never get stuck out of range.
    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [9:0] bcd_value(input logic [3:0] h, input logic [3:0] t,
                                             input logic [3:0] o);
        return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(o);
    endfunction

endpackage

// File: rtl/decimal_entry_game_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Turns a raw button level into a single one-clk press pulse. The input is
// sampled only on tick; after DEBOUNCE_TICKS consecutive high samples one
// pulse is emitted, and no further pulse is possible until a low sample.
// Ports:
//   clk, reset (async, active-high), tick (sample enable),
//   raw_i (button level), press_o (one-clk pulse)
// -----------------------------------------------------------------------------
module button_debounce #(
    parameter int unsigned DEBOUNCE_TICKS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic raw_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          press_q, press_d;

    // The counter saturates at DEBOUNCE_TICKS while the button is held, which
    // is what blocks repeat pulses until the button is released.
    always_comb begin
        cnt_d   = cnt_q;
        press_d = 1'b0;
        if (tick) begin
            if (!raw_i) begin
                cnt_d = '0;
            end else if (cnt_q != CW'(DEBOUNCE_TICKS)) begin
                cnt_d   = cnt_q + 1'b1;
                press_d = (cnt_q == CW'(DEBOUNCE_TICKS - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/decimal_entry_game.sv
// -----------------------------------------------------------------------------
// decimal_entry_game
// Player sees a random target in binary on the LEDs and enters its decimal
// value as three BCD digits (up = increment digit, next = move cursor,
// enter = submit). Correct answers increment a saturating score; a wrong
// answer clears it. The result is held for SHOW_TICKS ticks.
// Optional build macro: ENTRY_TIMEOUT_EN -- adds an idle timeout in ENTRY
// (TIMEOUT_TICKS ticks without an accepted press counts as a wrong answer).
// Ports:
//   clk, reset (async, active-high), tick (slow enable), rand_in[7:0],
//   up_button, next_button, enter_button (raw levels)
//   led[7:0] target, entry_bcd[11:0] {h,t,o}, cursor[1:0], score[7:0],
//   result_good, result_fail, state_out[2:0]
// -----------------------------------------------------------------------------
module decimal_entry_game
    import decimal_entry_game_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = 4,
    parameter int unsigned SHOW_TICKS     = 10
`ifdef ENTRY_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_TICKS  = 200
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic [7:0]  rand_in,
    input  logic        up_button,
    input  logic        next_button,
    input  logic        enter_button,
    output logic [7:0]  led,
    output logic [11:0] entry_bcd,
    output logic [1:0]  cursor,
    output logic [7:0]  score,
    output logic        result_good,
    output logic        result_fail,
    output logic [2:0]  state_out
);

    localparam int unsigned SW = $clog2(SHOW_TICKS + 1);

    logic up_p, next_p, enter_p;

    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_up (
        .clk(clk), .reset(reset), .tick(tick), .raw_i(up_button), .press_o(up_p)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_next (
        .clk(clk), .reset(reset), .tick(tick), .raw_i(next_button), .press_o(next_p)
    );
    button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db_enter (
        .clk(clk), .reset(reset), .tick(tick), .raw_i(enter_button), .press_o(enter_p)
    );

    state_e          state_q, state_d;
    logic [7:0]      target_q, target_d;
    logic [3:0]      hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic [1:0]      cursor_q, cursor_d;
    logic [7:0]      score_q, score_d;
    logic [SW-1:0]   show_cnt_q, show_cnt_d;
`ifdef ENTRY_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0]   entry_cnt_q, entry_cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        hund_d     = hund_q;
        tens_d     = tens_q;
        ones_d     = ones_q;
        cursor_d   = cursor_q;
        score_d    = score_q;
        show_cnt_d = show_cnt_q;
`ifdef ENTRY_TIMEOUT_EN
        entry_cnt_d = entry_cnt_q;
`endif
        case (state_q)
            ST_LOAD: begin
                target_d   = rand_in;
                hund_d     = '0;
                tens_d     = '0;
                ones_d     = '0;
                cursor_d   = '0;
                show_cnt_d = '0;
`ifdef ENTRY_TIMEOUT_EN
                entry_cnt_d = '0;
`endif
                state_d    = ST_ENTRY;
            end
            ST_ENTRY: begin
                // One action per cycle: enter beats up, up beats next.
                if (enter_p) begin
                    state_d = ST_CHECK;
                end else if (up_p) begin
                    case (cursor_q)
                        2'd0:    hund_d = digit_inc(hund_q, HUNDREDS_MAX);
                        2'd1:    tens_d = digit_inc(tens_q, DIGIT_MAX);
                        default: ones_d = digit_inc(ones_q, DIGIT_MAX);
                    endcase
                end else if (next_p) begin
                    case (cursor_q)
                        2'd0:    cursor_d = 2'd1;
                        2'd1:    cursor_d = 2'd2;
                        default: cursor_d = 2'd0;
                    endcase
                end
`ifdef ENTRY_TIMEOUT_EN
                if (enter_p || up_p || next_p) begin
                    entry_cnt_d = '0;
                end else if (tick) begin
                    if (entry_cnt_q == TW'(TIMEOUT_TICKS - 1)) begin
                        entry_cnt_d = '0;
                        score_d     = '0;
                        state_d     = ST_SHOW_FAIL;
                    end else begin
                        entry_cnt_d = entry_cnt_q + 1'b1;
                    end
                end
`endif
            end
            ST_CHECK: begin
                // Compared at 10 bits so entries above 255 (up to 299) never
                // alias onto an 8-bit target.
                if (bcd_value(hund_q, tens_q, ones_q) == {2'b00, target_q}) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                    state_d = ST_SHOW_GOOD;
                end else begin
                    score_d = '0;
                    state_d = ST_SHOW_FAIL;
                end
            end
            ST_SHOW_GOOD, ST_SHOW_FAIL: begin
                if (tick) begin
                    if (show_cnt_q == SW'(SHOW_TICKS - 1)) begin
                        show_cnt_d = '0;
                        state_d    = ST_LOAD;
                    end else begin
                        show_cnt_d = show_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_LOAD;
            target_q   <= '0;
            hund_q     <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
            cursor_q   <= '0;
            score_q    <= '0;
            show_cnt_q <= '0;
`ifdef ENTRY_TIMEOUT_EN
            entry_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            hund_q     <= hund_d;
            tens_q     <= tens_d;
            ones_q     <= ones_d;
            cursor_q   <= cursor_d;
            score_q    <= score_d;
            show_cnt_q <= show_cnt_d;
`ifdef ENTRY_TIMEOUT_EN
            entry_cnt_q <= entry_cnt_d;
`endif
        end
    end

    assign led         = target_q;
    assign entry_bcd   = {hund_q, tens_q, ones_q};
    assign cursor      = cursor_q;
    assign score       = score_q;
    assign result_good = (state_q == ST_SHOW_GOOD);
    assign result_fail = (state_q == ST_SHOW_FAIL);
    assign state_out   = state_q;

endmodule

// File: tb/tb_decimal_entry_game.sv
// -----------------------------------------------------------------------------
// tb_decimal_entry_game
// Directed bench: a table of button presses with expected digit/cursor/state/
// score after each, followed by hand-written sequences for show timing,
// debounce glitches, simultaneous presses, score saturation, asynchronous
// reset, ignored presses and the ENTRY idle behaviour.
// -----------------------------------------------------------------------------
module tb_decimal_entry_game;

    localparam int DEB  = 4;
    localparam int SHOW = 10;

    localparam logic [2:0] S_LOAD = 3'd0, S_ENTRY = 3'd1, S_CHECK = 3'd2,
                           S_GOOD = 3'd3, S_FAIL = 3'd4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic [7:0]  rand_in = 8'h2A;
    logic        up_button = 1'b0, next_button = 1'b0, enter_button = 1'b0;
    logic [7:0]  led;
    logic [11:0] entry_bcd;
    logic [1:0]  cursor;
    logic [7:0]  score;
    logic        result_good, result_fail;
    logic [2:0]  state_out;

    decimal_entry_game #(
        .DEBOUNCE_TICKS(DEB),
        .SHOW_TICKS    (SHOW)
`ifdef ENTRY_TIMEOUT_EN
        ,
        .TIMEOUT_TICKS (20)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .rand_in     (rand_in),
        .up_button   (up_button),
        .next_button (next_button),
        .enter_button(enter_button),
        .led         (led),
        .entry_bcd   (entry_bcd),
        .cursor      (cursor),
        .score       (score),
        .result_good (result_good),
        .result_fail (result_fail),
        .state_out   (state_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [2:0]  btn;     // {up, next, enter}
        logic [11:0] bcd;
        logic [1:0]  cur;
        logic [2:0]  st;
        logic [7:0]  sc;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick_once();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        @(negedge clk);
    endtask

    // Holds the buttons for exactly the debounce window; the action has been
    // taken by the FSM when this returns.
    task automatic press_hold(input logic u, input logic n, input logic e);
        up_button = u; next_button = n; enter_button = e;
        repeat (DEB) tick_once();
    endtask

    task automatic release_all();
        up_button = 1'b0; next_button = 1'b0; enter_button = 1'b0;
        tick_once();
    endtask

    task automatic press(input logic u, input logic n, input logic e);
        press_hold(u, n, e);
        release_all();
    endtask

    task automatic enter_value(input int v);
        for (int k = 0; k < v / 100; k++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < (v / 10) % 10; k++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < v % 10; k++) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
    endtask

    task automatic wait_entry();
        for (int i = 0; i < 3 * SHOW && state_out != S_ENTRY; i++) tick_once();
        check("wait_entry", 32'(state_out), 32'(S_ENTRY));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // btn {u,n,e}, entry_bcd, cursor, state, score; target is 0x2A = 42
        vecs[0]  = '{3'b100, 12'h100, 2'd0, S_ENTRY, 8'd0};
        vecs[1]  = '{3'b100, 12'h200, 2'd0, S_ENTRY, 8'd0};
        vecs[2]  = '{3'b100, 12'h000, 2'd0, S_ENTRY, 8'd0};  // hundreds wraps 2->0
        vecs[3]  = '{3'b010, 12'h000, 2'd1, S_ENTRY, 8'd0};
        vecs[4]  = '{3'b010, 12'h000, 2'd2, S_ENTRY, 8'd0};
        vecs[5]  = '{3'b010, 12'h000, 2'd0, S_ENTRY, 8'd0};  // cursor wraps
        vecs[6]  = '{3'b010, 12'h000, 2'd1, S_ENTRY, 8'd0};
        vecs[7]  = '{3'b100, 12'h010, 2'd1, S_ENTRY, 8'd0};
        vecs[8]  = '{3'b100, 12'h020, 2'd1, S_ENTRY, 8'd0};
        vecs[9]  = '{3'b100, 12'h030, 2'd1, S_ENTRY, 8'd0};
        vecs[10] = '{3'b100, 12'h040, 2'd1, S_ENTRY, 8'd0};
        vecs[11] = '{3'b010, 12'h040, 2'd2, S_ENTRY, 8'd0};
        vecs[12] = '{3'b100, 12'h041, 2'd2, S_ENTRY, 8'd0};
        vecs[13] = '{3'b100, 12'h042, 2'd2, S_ENTRY, 8'd0};
        vecs[14] = '{3'b001, 12'h042, 2'd2, S_GOOD,  8'd1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_led",   32'(led), 0);
        check("rst_bcd",   32'(entry_bcd), 0);
        check("rst_cursor", 32'(cursor), 0);
        check("rst_score", 32'(score), 0);
        check("rst_flags", 32'({result_good, result_fail}), 0);
        check("rst_state", 32'(state_out), 32'(S_LOAD));
        reset = 1'b0;
        @(negedge clk);
        check("load_state", 32'(state_out), 32'(S_ENTRY));
        check("load_led",   32'(led), 32'h2A);

        // Table-driven entry of 42
        for (int i = 0; i < 15; i++) begin
            press(vecs[i].btn[2], vecs[i].btn[1], vecs[i].btn[0]);
            $display("vec %0d btn=%b bcd=%h cur=%0d st=%0d score=%0d", i, vecs[i].btn,
                     entry_bcd, cursor, state_out, score);
            check($sformatf("vec%0d_bcd", i),   32'(entry_bcd), 32'(vecs[i].bcd));
            check($sformatf("vec%0d_cur", i),   32'(cursor),    32'(vecs[i].cur));
            check($sformatf("vec%0d_state", i), 32'(state_out), 32'(vecs[i].st));
            check($sformatf("vec%0d_score", i), 32'(score),     32'(vecs[i].sc));
        end
        check("good_flag", 32'({result_good, result_fail}), 32'b10);

        // Result held for exactly SHOW ticks, then LOAD for one clk, then ENTRY
        repeat (SHOW - 1) tick_once();
        check("show_hold", 32'(state_out), 32'(S_GOOD));
        rand_in = 8'h77;
        tick = 1'b1;
        @(negedge clk);
        check("show_to_load", 32'(state_out), 32'(S_LOAD));
        check("load_flags",   32'({result_good, result_fail}), 0);
        tick = 1'b0;
        @(negedge clk);
        check("reload_state", 32'(state_out), 32'(S_ENTRY));
        check("reload_led",   32'(led), 32'h77);
        check("reload_bcd",   32'(entry_bcd), 0);
        check("reload_cur",   32'(cursor), 0);

        // Two-tick glitch is rejected
        up_button = 1'b1;
        repeat (2) tick_once();
        up_button = 1'b0;
        tick_once();
        check("glitch_bcd", 32'(entry_bcd), 0);
        // Long hold gives exactly one action
        up_button = 1'b1;
        repeat (2 * DEB) tick_once();
        up_button = 1'b0;
        tick_once();
        check("hold_once_bcd", 32'(entry_bcd), 32'h100);

        // Up and enter in the same cycle: enter wins, digit untouched,
        // flag two clks after the pulse (100 != 0x77 -> fail)
        press_hold(1'b1, 1'b0, 1'b1);
        check("simul_state", 32'(state_out), 32'(S_CHECK));
        check("simul_bcd",   32'(entry_bcd), 32'h100);
        check("simul_noflag", 32'({result_good, result_fail}), 0);
        @(negedge clk);
        check("simul_flag",  32'({result_good, result_fail}), 32'b01);
        check("simul_score", 32'(score), 0);
        rand_in = 8'h00;
        release_all();
        wait_entry();

        // Build score to 5, then a wrong answer against 0xFF clears it
        for (int i = 1; i <= 5; i++) begin
            enter_value(0);
            check($sformatf("build%0d_score", i), 32'(score), 32'(i));
            check($sformatf("build%0d_good", i), 32'(result_good), 1);
            if (i == 5) rand_in = 8'hFF;
            wait_entry();
        end
        check("ff_led", 32'(led), 32'hFF);
        enter_value(254);
        check("wrong_state", 32'(state_out), 32'(S_FAIL));
        check("wrong_score", 32'(score), 0);
        check("wrong_bcd",   32'(entry_bcd), 32'h254);

        // Presses during SHOW_FAIL are ignored
        press(1'b1, 1'b1, 1'b0);
        check("ign_bcd",   32'(entry_bcd), 32'h254);
        check("ign_cur",   32'(cursor), 2);
        check("ign_state", 32'(state_out), 32'(S_FAIL));
        wait_entry();

        // 299 is over range for an 8-bit target
        enter_value(299);
        check("over_state", 32'(state_out), 32'(S_FAIL));
        check("over_bcd",   32'(entry_bcd), 32'h299);
        check("over_flag",  32'(result_fail), 1);
        rand_in = 8'h00;
        wait_entry();

        // Saturation at 255
        for (int i = 0; i < 255; i++) begin
            enter_value(0);
            if (i == 254) rand_in = 8'h05;
            wait_entry();
        end
        check("sat_pre_score", 32'(score), 255);
        enter_value(5);
        check("sat_score", 32'(score), 255);
        check("sat_state", 32'(state_out), 32'(S_GOOD));
        check("sat_bcd",   32'(entry_bcd), 32'h005);

        // Asynchronous reset between clock edges while in SHOW_GOOD
        #2 reset = 1'b1;
        #1;
        check("arst_led",   32'(led), 0);
        check("arst_bcd",   32'(entry_bcd), 0);
        check("arst_cur",   32'(cursor), 0);
        check("arst_score", 32'(score), 0);
        check("arst_flags", 32'({result_good, result_fail}), 0);
        check("arst_state", 32'(state_out), 32'(S_LOAD));
        rand_in = 8'h33;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_state", 32'(state_out), 32'(S_ENTRY));

`ifdef ENTRY_TIMEOUT_EN
        repeat (19) tick_once();
        check("to_before", 32'(state_out), 32'(S_ENTRY));
        tick_once();
        check("to_state", 32'(state_out), 32'(S_FAIL));
        check("to_score", 32'(score), 0);
        wait_entry();
`else
        repeat (1000) tick_once();
        check("idle_state", 32'(state_out), 32'(S_ENTRY));
`endif

        // Ones digit wraps 9->0
        press(1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            press(1'b1, 1'b0, 1'b0);
            check($sformatf("ones%0d", k), 32'(entry_bcd), 32'(k % 10));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
